hilo_mul_ctrl: RTL and testbench

Controller that sequences the registered 32x32 multiplier for the CPU EX stage and owns the architectural HI/LO registers. It accepts MULT/MULTU/MTHI/MTLO requests with a valid/ready handshake and drives the multiplier operand and sign inputs. It captures the 64-bit product into HI/LO after the programmed latency and serves MFHI/MFLO reads, stalling them while a product is pending. A pipeline flush (exception) cancels an in-flight multiply.

---
 rtl/hilo_mul_ctrl_pkg.sv | 29 ++
 rtl/hilo_mul_ctrl_regs.sv | 42 ++++
 rtl/hilo_mul_ctrl.sv | 128 ++++++++++++
 tb/tb_hilo_mul_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_mul_ctrl_pkg.sv
// hilo_mul_ctrl_pkg
//   Shared encodings for the HI/LO multiply controller: request opcodes,
//   controller states, legal multiplier latency bounds and the operand
//   bundle presented to the external multiplier.
package hilo_mul_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_MTHI  = 2'd2,
        OP_MTLO  = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int MUL_LAT_MIN = 1;
    localparam int MUL_LAT_MAX = 8;

    // Operand bundle driven to the multiplier and held across WAIT.
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        sgn;
    } mul_opnd_t;

endpackage

// File: rtl/hilo_mul_ctrl_regs.sv
// hilo_regs
//   Architectural HI/LO registers with independent move-to writes, a
//   full 64-bit product load and the MFHI/MFLO read mux.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   hi_we, lo_we    MTHI / MTLO write enables (data from wdata)
//   wdata           move-to data
//   prod_we, prod   load {hi,lo} from the multiplier product
//   rd_sel          0=LO, 1=HI
//   rd_data         selected register, combinational from the flops
module hilo_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        prod_we,
    input  logic [63:0] prod,
    input  logic        rd_sel,
    output logic [31:0] rd_data
);

    logic [31:0] hi, lo;

    // prod_we and the move-to enables are mutually exclusive (WAIT vs IDLE);
    // the product load is given priority anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (prod_we) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
        end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

    assign rd_data = rd_sel ? hi : lo;

endmodule

// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl
//   Sequences an external registered 32x32 multiplier for the EX stage and
//   owns HI/LO. MULT/MULTU issue in IDLE, then WAIT counts MUL_LAT cycles
//   and captures the product; MTHI/MTLO write directly in IDLE. Reads are
//   stalled while a product is pending; flush cancels an in-flight multiply.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake; req_op selects the op
//   src_a, src_b                  operands (src_a is also MTHI/MTLO data)
//   flush                         cancel pending multiply / drop request
//   mul_x, mul_y, mul_signed      multiplier operand and mode drive
//   mul_result                    multiplier product {hi,lo}
//   rd_req, rd_sel, rd_data       MFHI/MFLO read port
//   rd_stall, busy                read stall, multiply in flight
module hilo_mul_ctrl
    import hilo_mul_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    output logic        mul_signed,
    input  logic [63:0] mul_result,
    input  logic        rd_req,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        rd_stall,
    output logic        busy
);

    if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_bad_lat
        $error("hilo_mul_ctrl: MUL_LAT must be within 1..8");
    end

    localparam int CW = $clog2(MUL_LAT + 1);

    op_e              op;
    state_e           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    mul_opnd_t        held, held_nxt, drv;
    logic             hi_we, lo_we, prod_we;

    assign op = op_e'(req_op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            held  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            held  <= held_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        held_nxt  = held;
        drv       = '0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        prod_we   = 1'b0;
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                // flush drops this cycle's request entirely
                if (req_valid && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            // operands reach the multiplier in the issue cycle
                            drv       = '{x: src_a, y: src_b, sgn: (op == OP_MULT)};
                            held_nxt  = drv;
                            cnt_nxt   = CW'(MUL_LAT - 1);
                            state_nxt = ST_WAIT;
                        end
                        OP_MTHI: hi_we = 1'b1;
                        OP_MTLO: lo_we = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                drv  = held;
                if (flush) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (cnt == '0) begin
                    prod_we   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mul_x      = drv.x;
    assign mul_y      = drv.y;
    assign mul_signed = drv.sgn;
    assign rd_stall   = rd_req & (state == ST_WAIT);

    hilo_regs u_regs (
        .clk     (clk),
        .rst     (rst),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (src_a),
        .prod_we (prod_we),
        .prod    (mul_result),
        .rd_sel  (rd_sel),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
module tb_hilo_mul_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic [31:0] mul_x, mul_y;
    logic        mul_signed;
    logic [63:0] mul_result;
    logic        rd_req, rd_sel;
    logic [31:0] rd_data;
    logic        rd_stall, busy;

    always #5 clk = ~clk;

    hilo_mul_ctrl #(.MUL_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_signed (mul_signed),
        .mul_result (mul_result),
        .rd_req     (rd_req),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .rd_stall   (rd_stall),
        .busy       (busy)
    );

    // Plain arithmetic product, low 64 bits.
    function automatic logic [63:0] prod64(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        longint xa, xb;
        if (s) begin
            xa = longint'($signed(a));
            xb = longint'($signed(b));
        end else begin
            xa = longint'({32'b0, a});
            xb = longint'({32'b0, b});
        end
        return 64'(xa * xb);
    endfunction

    // Registered multiplier with LAT cycles of latency.
    logic [63:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= prod64(mul_x, mul_y, mul_signed);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_result = mpipe[LAT-1];

    // Reference model: architectural HI/LO plus cycles remaining on a pending multiply.
    logic [31:0] m_hi, m_lo, pa, pb;
    logic        ps;
    int          m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi <= 0; m_lo <= 0; m_left <= 0;
        end else if (m_left > 0) begin
            if (flush) m_left <= 0;
            else begin
                m_left <= m_left - 1;
                if (m_left == 1) {m_hi, m_lo} <= prod64(pa, pb, ps);
            end
        end else if (req_valid && !flush) begin
            case (req_op)
                2'd0, 2'd1: begin
                    m_left <= LAT; pa <= src_a; pb <= src_b; ps <= (req_op == 2'd0);
                end
                2'd2: m_hi <= src_a;
                default: m_lo <= src_a;
            endcase
        end
    end

    int          checks = 0, errors = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle handshake/drive checks plus scoreboard pop on accepted reads.
    always @(negedge clk) begin : mon
        logic        iss;
        logic [31:0] ex, ey;
        logic        es;
        if (!rst) begin
            iss = (m_left == 0) && req_valid && !flush && !req_op[1];
            ex  = iss ? src_a : (m_left > 0 ? pa : 32'd0);
            ey  = iss ? src_b : (m_left > 0 ? pb : 32'd0);
            es  = iss ? (req_op == 2'd0) : (m_left > 0 ? ps : 1'b0);
            chk("busy", busy, m_left > 0);
            chk("req_ready", req_ready, m_left == 0);
            chk("rd_stall", rd_stall, rd_req && m_left > 0);
            chk("rd_data", rd_data, rd_sel ? m_hi : m_lo);
            chk("mul_x", mul_x, ex);
            chk("mul_y", mul_y, ey);
            chk("mul_signed", mul_signed, es);
            if (rd_req && !rd_stall) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL read_accept: got unexpected accepted read, required none");
                end else begin
                    chk("rd_scoreboard", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1; req_op = op; src_a = a; src_b = b;
        tick();
        req_valid = 0;
    endtask

    // Hold a read until accepted; expected value goes to the scoreboard now.
    task automatic rd(input logic sel, input logic [31:0] exp, output int stalls);
        stalls = 0;
        rd_req = 1; rd_sel = sel;
        exp_q.push_back(exp);
        while (1) begin
            @(negedge clk);
            if (!rd_stall) break;
            stalls++;
            if (stalls > 20) begin
                checks++; errors++;
                $display("FAIL rd_timeout: got stall > 20 cycles, required release");
                exp_q.delete();
                break;
            end
        end
        tick();
        rd_req = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_left > 0) begin
            tick(); n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL idle_timeout: got busy > 50 cycles, required idle");
                break;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal;
    end

    initial begin
        int s, n;
        rst = 1; req_valid = 0; req_op = 0; src_a = 0; src_b = 0; flush = 0;
        rd_req = 0; rd_sel = 0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_stall", rd_stall, 0);
        chk("rst_mul", {mul_x, mul_y}, 0);
        chk("rst_sgn", mul_signed, 0);
        chk("rst_lo", rd_data, 0);
        rd_sel = 1; #1;
        chk("rst_hi", rd_data, 0);
        rd_sel = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // 1: MULT -1 x 2
        req_valid = 1; req_op = 2'd0; src_a = 32'hFFFF_FFFF; src_b = 32'h2;
        @(negedge clk);
        chk("t1_signed", mul_signed, 1);
        tick(); req_valid = 0;
        n = 0;
        while (busy && n < 50) begin n++; tick(); end
        chk("t1_busy_cycles", n, LAT);
        rd(1, 32'hFFFF_FFFF, s);
        rd(0, 32'hFFFF_FFFE, s);

        // 2: MULTU same operands
        req_valid = 1; req_op = 2'd1;
        @(negedge clk);
        chk("t2_signed", mul_signed, 0);
        tick(); req_valid = 0;
        wait_idle();
        rd(1, 32'h1, s);
        rd(0, 32'hFFFF_FFFE, s);

        // 3: MFHI held through WAIT
        issue(2'd0, 32'h0001_0000, 32'h0001_0000);
        rd(1, 32'h1, s);
        chk("t3_stall_cycles", s, LAT);
        rd(0, 32'h0, s);

        // 4: flush on second WAIT cycle
        issue(2'd0, 32'd5, 32'd7);
        tick();
        flush = 1; tick(); flush = 0;
        chk("t4_busy", busy, 0);
        chk("t4_ready", req_ready, 1);
        rd(1, 32'h1, s);
        rd(0, 32'h0, s);

        // 5: MTHI, MTLO back to back, then MULT 3x4
        req_valid = 1; req_op = 2'd2; src_a = 32'h1234_5678; tick();
        req_op = 2'd3; src_a = 32'h9ABC_DEF0; tick();
        req_valid = 0;
        rd(1, 32'h1234_5678, s);
        rd(0, 32'h9ABC_DEF0, s);
        issue(2'd0, 32'd3, 32'd4);
        wait_idle();
        rd(1, 32'h0, s);
        rd(0, 32'hC, s);

        // 6: asynchronous reset mid-WAIT
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        #1 rst = 1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_ready", req_ready, 1);
        rd_sel = 1; #1;
        chk("t6_hi", rd_data, 0);
        rd_sel = 0; #1;
        chk("t6_lo", rd_data, 0);
        @(posedge clk); #1 rst = 0;
        repeat (LAT + 2) tick();
        rd(1, 32'h0, s);
        rd(0, 32'h0, s);

        // Random traffic: requests, flushes and reads freely mixed.
        repeat (400) begin
            req_valid = $urandom_range(0, 1);
            req_op    = 2'($urandom_range(0, 3));
            src_a     = pick();
            src_b     = pick();
            flush     = ($urandom_range(0, 5) == 0);
            rd_sel    = $urandom_range(0, 1);
            rd_req    = ($urandom_range(0, 2) == 0);
            if (rd_req && m_left == 0) exp_q.push_back(rd_sel ? m_hi : m_lo);
            tick();
        end
        req_valid = 0; flush = 0; rd_req = 0;
        wait_idle();
        tick();
        chk("sb_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
